// File: rtl/x_memarb.sv
// Four-requester round-robin arbiter for the crossbar main port, routing read completions by ID FIFO.
// Latency: zero-cycle grant/accept and zero-cycle completion routing; ID FIFO updates on the clock edge.
// Backpressure: a stalled main port locks the grant; reads are held off while the ID FIFO is full.
module x_memarb #(
   parameter int p_depth = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [3:0]                 i_req_valid,
   output logic [3:0]                 o_req_accept,
   input  logic [3:0]                 i_req_rd_n_wr,
   input  logic [75:0]                i_req_addr,
   input  logic [31:0]                i_req_wdata,
   output logic [3:0]                 o_req_ready,
   output logic [7:0]                 o_req_rdata,
   output logic                       o_main_valid,
   input  logic                       i_main_accept,
   output logic                       o_main_rd_n_wr,
   output logic [18:0]                o_main_addr,
   output logic [7:0]                 o_main_wdata,
   input  logic                       i_main_ready,
   input  logic [7:0]                 i_main_rdata,
   output logic [$clog2(p_depth):0]   o_outstanding,
   output logic                       o_err
);

   localparam int c_aw = $clog2(p_depth);

   logic [3:0]      elig;
   logic [1:0]      grant;
   logic [1:0]      sel;
   logic [1:0]      idx;
   logic            found;
   logic            hs;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;

   logic            lock_q, lock_d;
   logic [1:0]      locked_id_q, locked_id_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic [c_aw:0]   wr_ptr_q, wr_ptr_d;
   logic [c_aw:0]   rd_ptr_q, rd_ptr_d;
   logic [1:0]      mem_q [p_depth];
   logic [1:0]      mem_d [p_depth];
   logic            err_q, err_d;

   assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
   assign fifo_full     = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                          (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
   assign o_outstanding = wr_ptr_q - rd_ptr_q;
   assign o_err         = err_q;

   // Eligibility and round-robin grant; a locked grant overrides the search
   always_comb begin
      elig  = i_req_valid & (~i_req_rd_n_wr | {4{~fifo_full}});
      grant = rr_ptr_q;
      found = 1'b0;
      idx   = 2'd0;
      if (lock_q) begin
         grant = locked_id_q;
      end else begin
         for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && elig[idx]) begin
               grant = idx;
               found = 1'b1;
            end
         end
      end
   end

   assign o_main_valid = (|elig) | lock_q;
   assign hs           = o_main_valid & i_main_accept;
   assign push         = hs & o_main_rd_n_wr;
   assign pop          = i_main_ready & ~fifo_empty;
   assign o_req_accept = hs ? (4'b0001 << grant) : 4'b0000;
   assign o_req_ready  = pop ? (4'b0001 << mem_q[rd_ptr_q[c_aw-1:0]]) : 4'b0000;
   assign o_req_rdata  = i_main_rdata;

   // Main-port payload mux; idle port shows requester 0
   always_comb begin
      sel = o_main_valid ? grant : 2'd0;
      o_main_rd_n_wr = i_req_rd_n_wr[0];
      o_main_addr    = i_req_addr[18:0];
      o_main_wdata   = i_req_wdata[7:0];
      case (sel)
         2'd1: begin
            o_main_rd_n_wr = i_req_rd_n_wr[1];
            o_main_addr    = i_req_addr[37:19];
            o_main_wdata   = i_req_wdata[15:8];
         end
         2'd2: begin
            o_main_rd_n_wr = i_req_rd_n_wr[2];
            o_main_addr    = i_req_addr[56:38];
            o_main_wdata   = i_req_wdata[23:16];
         end
         2'd3: begin
            o_main_rd_n_wr = i_req_rd_n_wr[3];
            o_main_addr    = i_req_addr[75:57];
            o_main_wdata   = i_req_wdata[31:24];
         end
         default: ;
      endcase
   end

   // Next state: lock/rr pointer, ID FIFO pointers and storage, sticky error
   always_comb begin
      lock_d      = lock_q;
      locked_id_d = locked_id_q;
      rr_ptr_d    = rr_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      for (int i = 0; i < p_depth; i++) mem_d[i] = mem_q[i];
      err_d       = err_q | (i_main_ready & fifo_empty);

      if (hs) begin
         lock_d   = 1'b0;
         rr_ptr_d = grant + 2'd1;
      end else if (o_main_valid) begin
         lock_d      = 1'b1;
         locked_id_d = grant;
      end

      if (push) begin
         mem_d[wr_ptr_q[c_aw-1:0]] = grant;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // State registers, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lock_q      <= 1'b0;
         locked_id_q <= 2'd0;
         rr_ptr_q    <= 2'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int i = 0; i < p_depth; i++) mem_q[i] <= 2'd0;
         err_q       <= 1'b0;
      end else begin
         lock_q      <= lock_d;
         locked_id_q <= locked_id_d;
         rr_ptr_q    <= rr_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         for (int i = 0; i < p_depth; i++) mem_q[i] <= mem_d[i];
         err_q       <= err_d;
      end
   end

endmodule

// File: doc/x_memarb.md
Name: x_memarb

Overview:
- Four-requester round-robin arbiter that shares the single main port of the memory crossbar (x_memxbar) between independent masters.
- Forwards one request per handshake onto the main port.
- Records the requester ID of every accepted read in an ID FIFO. Read completions return from the crossbar in request order, so each completion is routed to the requester at the FIFO head.
- Writes produce no completion and are not recorded.

Parameters:
- p_depth, 4: ID FIFO entries (power of 2, >=2); the maximum number of reads outstanding across all requesters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  4  per-requester request valid, bit r = requester r
- o_req_accept  out  4  per-requester accept (one-hot or zero)
- i_req_rd_n_wr  in  4  per-requester 1=read, 0=write
- i_req_addr  in  76  requester r at bits [19r+18:19r]
- i_req_wdata  in  32  requester r at bits [8r+7:8r]
- o_req_ready  out  4  per-requester read completion strobe (one-hot or zero)
- o_req_rdata  out  8  completion data, broadcast to all requesters, qualified by o_req_ready
- o_main_valid  out  1  to crossbar i_main_valid
- i_main_accept  in  1  from crossbar o_main_accept
- o_main_rd_n_wr  out  1  to crossbar
- o_main_addr  out  19  to crossbar
- o_main_wdata  out  8  to crossbar
- i_main_ready  in  1  from crossbar o_main_ready
- i_main_rdata  in  8  from crossbar o_main_rdata
- o_outstanding  out  log2(p_depth)+1  number of reads accepted but not yet completed
- o_err  out  1  sticky: completion received with ID FIFO empty

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - rr_ptr=0, lock=0, FIFO empty, o_outstanding=0, o_err=0.
  - o_req_accept=0, o_req_ready=0, o_main_valid=0.
- Eligibility: requester r is eligible when i_req_valid[r] & (!i_req_rd_n_wr[r] | !fifo_full).
  - Writes are never blocked by FIFO full.
- Grant, combinational from eligible, rr_ptr and lock:
  - lock=0: grant the first eligible requester searching rr_ptr, rr_ptr+1, ... mod 4.
  - lock=1: grant = locked_id, whatever the other requests are.
- Main port: o_main_valid = (any eligible) | lock. o_main_rd_n_wr, o_main_addr and o_main_wdata are muxed from the granted requester.
  - With no grant, data outputs are don't-care; drive them from requester 0.
- Accept: o_req_accept[g] = i_main_accept & o_main_valid; zero latency.
- Lock register (keeps the main port stable under valid/accept rules):
  - o_main_valid & !i_main_accept: at the next edge, lock<=1 and locked_id<=grant.
  - Handshake (o_main_valid & i_main_accept): lock<=0 and rr_ptr<=grant+1 (mod 4).
  - Requesters must hold valid and payload until accepted. A requester dropping valid while locked is a protocol violation; behaviour is undefined and not checked.
- FIFO push: on handshake with o_main_rd_n_wr=1, push the 2-bit grant ID.
- FIFO pop: on i_main_ready with FIFO non-empty.
  - o_req_ready = onehot(head_id) & {4{i_main_ready & !fifo_empty}}; zero latency.
  - o_req_rdata = i_main_rdata.
- i_main_ready with FIFO empty: no pop, o_req_ready=0, o_err<=1. o_err clears only on reset.
- Simultaneous push and pop: both occur and o_outstanding is unchanged.
  - Push into a full FIFO is impossible, because read eligibility requires !fifo_full at grant time. Lock cannot start a new read while the FIFO is full, because pops only reduce occupancy.
  - Push into an empty FIFO with a same-cycle ready: the ready sees empty, so it is an error. No bypass.
- FIFO pointers are log2(p_depth)+1 bits and wrap naturally.
  - full: the MSBs of the write and read pointers differ and the rest of the bits are equal.
  - o_outstanding = wr_ptr - rd_ptr.
- Reset mid-operation: the FIFO and lock clear immediately. Completions for pre-reset reads then flag o_err; the crossbar is reset alongside in normal use.

Test Plan:
- Single requester 2 reads, addr 0x00010 then 0x00011, crossbar accepts the same cycle -> o_req_accept[2] pulses twice, o_outstanding=2; two i_main_ready with rdata 0xA5, 0x5A -> o_req_ready=4'b0100 twice with matching data, o_outstanding=0.
- All 4 requesters continuously valid (writes), i_main_accept=1 -> grant order 0,1,2,3,0,... with one accept per cycle; o_outstanding stays 0.
- Requester 1 valid, i_main_accept held low 3 cycles while requester 0 raises valid -> main port stays on requester 1's addr/data; after accept, requester 2..0 search order grants requester 0 next.
- p_depth=4: 4 reads accepted, no completions; requester 3 read plus requester 0 write valid -> only the write is accepted; one completion frees a slot -> requester 3's read is accepted the following handshake.
- Reads interleaved from requesters 0,3,1 -> completions route o_req_ready 0001, 1000, 0010 in order. Same-cycle push and pop at o_outstanding=2 keeps it at 2.
- i_main_ready with FIFO empty -> o_err=1 from the next cycle and stays set, o_req_ready=0. Assert i_rst_n low mid-stream -> all outputs return to reset values asynchronously and o_err clears.
